// File: rtl/hsv_conv_if.sv
// Handshake and pixel/result bus for the HSV converter.
interface hsv_conv_if #(
  parameter int DW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] r;
  logic [DW-1:0] g;
  logic [DW-1:0] b;
  logic [DW-1:0] max_val;
  logic [1:0]    max_idx;
  logic [DW-1:0] min_val;
  logic          out_valid;
  logic          out_ready;
  logic [10:0]   hue;
  logic [7:0]    sat;
  logic [DW-1:0] val;

  modport master (
    output in_valid, r, g, b, max_val, max_idx, min_val, out_ready,
    input  in_ready, out_valid, hue, sat, val
  );

  modport slave (
    input  in_valid, r, g, b, max_val, max_idx, min_val, out_ready,
    output in_ready, out_valid, hue, sat, val
  );
endinterface

// File: rtl/hsv_conv.sv
// RGB -> HSV converter back end: takes max/min from an upstream stage, runs two
// parallel 9-step restoring dividers (hue fraction and saturation) and holds
// the result until the consumer accepts it.
module hsv_conv #(
  parameter int DW = 10
) (
  input logic     clk,
  input logic     rst,
  hsv_conv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [DW-1:0] delta_q;
  logic [DW-1:0] maxv_q;
  logic [1:0]    eff_q;
  logic          neg_q;
  logic [DW:0]   rem_h, rem_s;
  logic [7:0]    q_h, q_s;

  // Capture-side decode: effective max index, channel difference and its sign.
  logic [DW-1:0] sel_ch, a_ch, c_ch, num_in, delta_in;
  logic [1:0]    eff_in;
  logic          sel_hit, neg_in;

  // Resolve which channel is the maximum and the two channels to subtract.
  always_comb begin
    sel_ch  = '0;
    sel_hit = 1'b0;
    eff_in  = 2'd0;
    a_ch    = '0;
    c_ch    = '0;
    case (bus.max_idx)
      2'd0:    begin sel_ch = bus.r; sel_hit = 1'b1; end
      2'd1:    begin sel_ch = bus.g; sel_hit = 1'b1; end
      2'd2:    begin sel_ch = bus.b; sel_hit = 1'b1; end
      default: begin sel_ch = '0;    sel_hit = 1'b0; end
    endcase
    if (sel_hit && sel_ch == bus.max_val) eff_in = bus.max_idx;
    else if (bus.r == bus.max_val)        eff_in = 2'd0;
    else if (bus.g == bus.max_val)        eff_in = 2'd1;
    else if (bus.b == bus.max_val)        eff_in = 2'd2;
    else                                  eff_in = 2'd0;
    case (eff_in)
      2'd1:    begin a_ch = bus.b; c_ch = bus.r; end
      2'd2:    begin a_ch = bus.r; c_ch = bus.g; end
      default: begin a_ch = bus.g; c_ch = bus.b; end
    endcase
    neg_in   = a_ch < c_ch;
    num_in   = neg_in ? (c_ch - a_ch) : (a_ch - c_ch);
    delta_in = bus.max_val - bus.min_val;
  end

  // One restoring-division step for each divider, plus final result shaping.
  logic [DW+1:0] trial_h, trial_s;
  logic [DW:0]   sel_h, sel_s, rem_h_nx, rem_s_nx;
  logic          bit_h, bit_s, last;
  logic [8:0]    qh_fin, qs_fin;
  logic [10:0]   base, qh11, hue_fin;
  logic [7:0]    sat_fin;

  // Trial-subtract the divisor; keep the difference when it does not borrow.
  always_comb begin
    trial_h  = {1'b0, rem_h} - {2'b00, delta_q};
    trial_s  = {1'b0, rem_s} - {2'b00, maxv_q};
    bit_h    = ~trial_h[DW+1];
    bit_s    = ~trial_s[DW+1];
    sel_h    = bit_h ? trial_h[DW:0] : rem_h;
    sel_s    = bit_s ? trial_s[DW:0] : rem_s;
    rem_h_nx = sel_h << 1;
    rem_s_nx = sel_s << 1;
    last     = (cnt == 4'd8);
    qh_fin   = {q_h, bit_h};
    qs_fin   = {q_s, bit_s};
    base     = {eff_q, 9'd0};
    qh11     = {2'b00, qh_fin};
    if (delta_q == '0)       hue_fin = '0;
    else if (!neg_q)         hue_fin = base + qh11;
    else if (eff_q == 2'd0)  hue_fin = (qh_fin == '0) ? 11'd0 : 11'd1536 - qh11;
    else                     hue_fin = base - qh11;
    if (maxv_q == '0)        sat_fin = '0;
    else if (qs_fin[8])      sat_fin = 8'hFF;
    else                     sat_fin = qs_fin[7:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = DIV;
      end
      DIV: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, division steps and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      delta_q <= '0;
      maxv_q  <= '0;
      eff_q   <= '0;
      neg_q   <= 1'b0;
      rem_h   <= '0;
      rem_s   <= '0;
      q_h     <= '0;
      q_s     <= '0;
      bus.hue <= '0;
      bus.sat <= '0;
      bus.val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            delta_q <= delta_in;
            maxv_q  <= bus.max_val;
            eff_q   <= eff_in;
            neg_q   <= neg_in;
            rem_h   <= {1'b0, num_in};
            rem_s   <= {1'b0, delta_in};
            q_h     <= '0;
            q_s     <= '0;
            cnt     <= '0;
          end
        end
        DIV: begin
          rem_h <= rem_h_nx;
          rem_s <= rem_s_nx;
          q_h   <= qh_fin[7:0];
          q_s   <= qs_fin[7:0];
          // The ninth quotient bit is folded in combinationally so the result
          // registers load on the same edge as the last step.
          if (last) begin
            cnt     <= '0;
            bus.hue <= hue_fin;
            bus.sat <= sat_fin;
            bus.val <= maxv_q;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
